// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states,
// the latched request record and byte-size helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef struct packed {
        logic        load;
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] wdata;
    } lsu_req_t;

    // funct3[1:0] encodes log2 of the access size in bytes
    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] lo);
        logic r;
        case (sz)
            2'b00:   r = 1'b0;
            2'b01:   r = lo[0];
            2'b10:   r = |lo[1:0];
            default: r = |lo;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: extracts and extends load data, and merges store bytes
// into a previously read doubleword for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [63:0] read_data,
    input  logic [63:0] old_data,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged_data
);

    logic [63:0] mask;

    assign mask        = size_mask(funct3[1:0]);
    assign merged_data = (old_data & ~mask) | (wdata & mask);

    always_comb begin
        load_data = read_data;
        case (funct3)
            F3_B:    load_data = {{56{read_data[7]}},  read_data[7:0]};
            F3_H:    load_data = {{48{read_data[15]}}, read_data[15:0]};
            F3_W:    load_data = {{32{read_data[31]}}, read_data[31:0]};
            F3_BU:   load_data = {56'd0, read_data[7:0]};
            F3_HU:   load_data = {48'd0, read_data[15:0]};
            F3_WU:   load_data = {32'd0, read_data[31:0]};
            default: load_data = read_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes a pipeline memory request and
// sequences reads, writes or read-modify-writes against an 8-byte memory port.
//
// state   | meaning
// IDLE    | ready for a request
// RD      | memory read (load data or RMW old doubleword)
// WR      | memory write
// RESP    | one-cycle response pulse
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [63:0] Read_Data
);

    logic [1:0]  state;
    lsu_req_t    req_q;
    logic [63:0] rmw_q;
    logic [63:0] rdata_q;
    logic        error_q;
    logic        req_err;
    logic [63:0] load_data;
    logic [63:0] merged_data;

    assign req_err = (req_funct3 == F3_ILL)
                   | (!req_load && req_funct3[2])
                   | is_misaligned(req_funct3[1:0], req_addr[2:0]);

    lsu_align u_align (
        .funct3      (req_q.funct3),
        .read_data   (Read_Data),
        .old_data    (rmw_q),
        .wdata       (req_q.wdata),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    // Response registers only change on the edge into RESP so they hold between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            rmw_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q.load   <= req_load;
                        req_q.funct3 <= req_funct3;
                        req_q.addr   <= req_addr;
                        req_q.wdata  <= req_wdata;
                        if (req_err) begin
                            state   <= ST_RESP;
                            rdata_q <= '0;
                            error_q <= 1'b1;
                        end else if (req_load || req_funct3[1:0] != 2'b11) begin
                            state <= ST_RD;
                        end else begin
                            state <= ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    rmw_q <= Read_Data;
                    if (req_q.load) begin
                        state   <= ST_RESP;
                        rdata_q <= load_data;
                        error_q <= 1'b0;
                    end else begin
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    state   <= ST_RESP;
                    rdata_q <= '0;
                    error_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;
    assign MemRead    = (state == ST_RD);
    assign MemWrite   = (state == ST_WR);
    assign Mem_Addr   = (MemRead || MemWrite) ? req_q.addr : '0;
    assign Write_Data = !MemWrite                  ? '0 :
                        (req_q.funct3[1:0] == 2'b11) ? req_q.wdata : merged_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// operations compared against a byte-array reference memory.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Read_Data;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_Data  (Read_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        Read_Data = '0;
        if (MemRead)
            for (int i = 0; i < 8; i++)
                Read_Data[8*i +: 8] = mem[8'(Mem_Addr[7:0] + 8'(i))];
    end

    always @(posedge clk)
        if (MemWrite)
            for (int i = 0; i < 8; i++)
                mem[8'(Mem_Addr[7:0] + 8'(i))] <= Write_Data[8*i +: 8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] dword_at(input logic [63:0] a, input bit from_ref);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++)
            v[8*i +: 8] = from_ref ? ref_mem[8'(a[7:0] + 8'(i))] : mem[8'(a[7:0] + 8'(i))];
        return v;
    endfunction

    task automatic set_dword(input logic [63:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            mem[8'(a[7:0] + 8'(i))]     = v[8*i +: 8];
            ref_mem[8'(a[7:0] + 8'(i))] = v[8*i +: 8];
        end
    endtask

    // Value a load should return: little-endian bytes, then two's-complement sign fix-up
    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] f3);
        int          n = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++)
            v = v + ({56'd0, ref_mem[8'(a[7:0] + 8'(i))]} << (8 * i));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    task automatic run_op(input logic ld, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input string tag);
        int          n = 1 << f3[1:0];
        bit          err = (f3 == 3'b111) || (!ld && f3[2]) || ((a % n) != 0);
        int          lat = err ? 1 : (ld || n == 8) ? 2 : 3;
        logic [63:0] exp_rd = (ld && !err) ? ref_load(a, f3) : 64'd0;
        logic [63:0] exp_wd = '0;
        bit          seen_rd = 0, seen_wr = 0;
        int          rcyc = 0, wcyc = 0;
        logic [63:0] rd_addr = '0, wd_obs = '0, got_rd = '0, resp_maddr = '0;
        logic        got_err = 0;
        for (int i = 0; i < 8; i++)
            exp_wd[8*i +: 8] = (i < n) ? wd[8*i +: 8] : ref_mem[8'(a[7:0] + 8'(i))];

        @(negedge clk);
        check({tag, ":ready_before"}, 64'(req_ready), 64'd1);
        req_valid = 1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        for (int k = 1; k <= 8 && rcyc == 0; k++) begin
            @(negedge clk);
            if (MemRead)  begin seen_rd = 1; rd_addr = Mem_Addr; end
            if (MemWrite) begin seen_wr = 1; wd_obs = Write_Data; wcyc = k; end
            if (resp_valid) begin
                rcyc = k; got_rd = resp_rdata; got_err = resp_error; resp_maddr = Mem_Addr;
            end
        end
        check({tag, ":latency"}, 64'(rcyc), 64'(lat));
        check({tag, ":error"}, 64'(got_err), 64'(err));
        check({tag, ":rdata"}, got_rd, exp_rd);
        check({tag, ":memread_seen"}, 64'(seen_rd), 64'(!err && (ld || n < 8)));
        check({tag, ":memwrite_seen"}, 64'(seen_wr), 64'(!err && !ld));
        check({tag, ":resp_mem_addr_idle"}, resp_maddr, 64'd0);
        if (seen_rd) check({tag, ":mem_addr"}, rd_addr, a);
        if (!err && !ld) begin
            check({tag, ":write_data"}, wd_obs, exp_wd);
            check({tag, ":write_cycle"}, 64'(wcyc), 64'(lat - 1));
            for (int i = 0; i < n; i++) ref_mem[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
        end
        @(negedge clk);
        check({tag, ":rdata_hold"}, resp_rdata, exp_rd);
        check({tag, ":ready_after"}, 64'(req_ready), 64'd1);
        check({tag, ":memory"}, dword_at(a, 0), dword_at(a, 1));
    endtask

    initial begin
        logic [63:0] b2b_addr [3];
        logic [63:0] resp_q [$];
        int          resp_cyc [$];
        int          n_acc;
        bit          acc;
        bit          seen_wr, seen_resp;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        set_dword(0,  64'd100);
        set_dword(8,  {56'd0, 8'h80});
        set_dword(16, 64'h1122_3344_5566_777D);

        reset = 1; req_valid = 0; req_load = 0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        req_valid = 1; req_load = 1; req_funct3 = 3'b011; req_addr = 64'd0;
        @(posedge clk); #1;
        reset = 0; req_valid = 0;
        @(negedge clk);
        check("rst:req_ready",  64'(req_ready),  64'd1);
        check("rst:resp_valid", 64'(resp_valid), 64'd0);
        check("rst:resp_rdata", resp_rdata,      64'd0);
        check("rst:resp_error", 64'(resp_error), 64'd0);
        check("rst:memread",    64'(MemRead),    64'd0);
        check("rst:memwrite",   64'(MemWrite),   64'd0);
        check("rst:mem_addr",   Mem_Addr,        64'd0);
        check("rst:write_data", Write_Data,      64'd0);

        run_op(1, 3'b011, 64'd0,  64'd0,  "ld_0");
        run_op(1, 3'b000, 64'd8,  64'd0,  "lb_8");
        run_op(1, 3'b100, 64'd8,  64'd0,  "lbu_8");
        run_op(0, 3'b000, 64'd16, 64'hAB, "sb_16");
        run_op(1, 3'b011, 64'd16, 64'd0,  "ld_16_after_sb");
        run_op(1, 3'b010, 64'd2,  64'd0,  "lw_2_misaligned");
        run_op(1, 3'b111, 64'd0,  64'd0,  "illegal_f3");
        run_op(0, 3'b100, 64'd0,  64'd5,  "store_unsigned_f3");
        run_op(0, 3'b011, 64'd32, 64'hDEAD_BEEF_0123_4567, "sd_32");

        // Reset lands while the SH read-modify-write is in RD
        @(negedge clk);
        req_valid = 1; req_load = 0; req_funct3 = 3'b001; req_addr = 64'd24;
        req_wdata = {$urandom, $urandom};
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        check("rmw_rst:in_rd", 64'(MemRead), 64'd1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("rmw_rst:req_ready", 64'(req_ready), 64'd1);
        seen_wr = 0; seen_resp = 0;
        repeat (5) begin
            if (MemWrite) seen_wr = 1;
            if (resp_valid) seen_resp = 1;
            @(negedge clk);
        end
        check("rmw_rst:memwrite", 64'(seen_wr),   64'd0);
        check("rmw_rst:resp",     64'(seen_resp), 64'd0);
        check("rmw_rst:memory",   dword_at(24, 0), dword_at(24, 1));

        // req_valid held high across three loads
        b2b_addr[0] = 64'd40; b2b_addr[1] = 64'd48; b2b_addr[2] = 64'd56;
        n_acc = 0;
        @(negedge clk);
        req_valid = 1; req_load = 1; req_funct3 = 3'b011; req_addr = b2b_addr[0];
        for (int t = 0; t < 16; t++) begin
            if (t > 0) @(negedge clk);
            if (resp_valid) begin resp_q.push_back(resp_rdata); resp_cyc.push_back(t); end
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                if (n_acc == 3) req_valid = 0;
                else req_addr = b2b_addr[n_acc];
            end
        end
        check("b2b:accepts", 64'(n_acc), 64'd3);
        check("b2b:responses", 64'(resp_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < resp_q.size(); i++)
            check($sformatf("b2b:rdata%0d", i), resp_q[i], ref_load(b2b_addr[i], 3'b011));
        for (int i = 1; i < resp_cyc.size(); i++)
            check($sformatf("b2b:interval%0d", i), 64'(resp_cyc[i] - resp_cyc[i-1]), 64'd3);

        for (int r = 0; r < 60; r++) begin
            logic [63:0] a;
            a = 64'($urandom_range(0, 30) * 8);
            if ($urandom_range(0, 3) == 0) a = a + 64'($urandom_range(0, 7));
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                   {$urandom, $urandom}, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1 bit: pipeline presents a memory operation.
REQ-004 SHALL have port req_ready, output, 1 bit: unit can accept a request; high only in IDLE.
REQ-005 SHALL have port req_load, input, 1 bit: 1 = load, 0 = store.
REQ-006 SHALL have port req_funct3, input, 3 bits, encoded as: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
REQ-007 SHALL have port req_addr, input, 64 bits: byte address.
REQ-008 SHALL have port req_wdata, input, 64 bits: store data, right-justified.
REQ-009 SHALL have port resp_valid, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 64 bits: extended load result; 0 for stores and errors.
REQ-011 SHALL have port resp_error, output, 1 bit: misaligned access or illegal funct3; valid with resp_valid.
REQ-012 SHALL have memory-side ports Mem_Addr (output, 64 bits), Write_Data (output, 64 bits), MemRead (output, 1 bit), MemWrite (output, 1 bit) and Read_Data (input, 64 bits).
REQ-013 SHALL treat the memory as follows: 8-byte little-endian access starting at Mem_Addr; Read_Data combinational from Mem_Addr and MemRead; write committed on the clk edge while MemWrite=1.

Function
REQ-014 SHALL accept a request on a clk edge where req_valid=1 and req_ready=1, latching load, funct3, addr and wdata.
REQ-015 SHALL implement the FSM states IDLE, RD, WR and RESP; MemRead=1 only in RD and MemWrite=1 only in WR, both decoded from the state register.
REQ-016 SHALL sequence each operation type as follows, where C is the accept edge:
- load: IDLE->RD->RESP, resp_valid during cycle C+2.
- store D: IDLE->WR->RESP, resp_valid during cycle C+2.
- store B/H/W: IDLE->RD->WR->RESP (read-modify-write), resp_valid during cycle C+3.
- error: IDLE->RESP, resp_valid during cycle C+1, with no MemRead or MemWrite.
REQ-017 SHALL transition RESP->IDLE unconditionally after one cycle, with no backpressure on the response.
REQ-018 SHALL drive Mem_Addr from the latched address, held constant from RD through WR.
REQ-019 SHALL, on a load, sample Read_Data at the end of RD, take its low 1/2/4/8 bytes, and sign-extend (B/H/W) or zero-extend (BU/HU/WU; D unchanged).
REQ-020 SHALL, on a sub-doubleword store, capture Read_Data in RD and drive Write_Data in WR as the captured doubleword with its low 1/2/4 bytes replaced by req_wdata's low bytes; the upper bytes SHALL be preserved exactly.
REQ-021 SHALL drive Write_Data=req_wdata unmodified on a store D.
REQ-022 SHALL flag misalignment when addr mod size != 0 (H: bit0; W: bits1:0; D: bits2:0; B never misaligned).
REQ-023 SHALL treat funct3 111 as an error, and also funct3 1xx on a store.
REQ-024 SHALL ignore req_valid while req_ready=0 and never queue requests; one request SHALL be accepted per IDLE cycle at most, so the back-to-back issue interval is latency+1.
REQ-025 SHALL hold resp_rdata and resp_error until the next resp_valid.
REQ-026 SHALL drive Mem_Addr, Write_Data, MemRead and MemWrite to 0 in IDLE and RESP.

Reset
REQ-027 SHALL, on a reset edge, set: state IDLE; resp_valid 0; resp_rdata 0; resp_error 0; Mem_Addr 0; Write_Data 0; MemRead 0; MemWrite 0; req_ready 1 from the following cycle.
REQ-028 SHALL abort any operation in progress when reset is asserted mid-operation, including RD of a read-modify-write: no subsequent MemWrite is issued and no resp_valid is produced.
REQ-029 SHALL give reset priority over a request arriving on the same edge, which is not accepted.

Structure
REQ-030 SHALL place the funct3 encodings, the FSM state encoding and the size-to-mask function in shared package lsu_pkg.
REQ-031 SHALL place the combinational byte-lane extract/extend and merge logic in sub-module lsu_align, instantiated once.

Verification
REQ-032 SHALL cover: memory bytes 0..7 = {100,0,...}, load D at addr 0 -> resp_valid at C+2, resp_rdata=64'd100, resp_error=0.
REQ-033 SHALL cover: byte at addr 8 = 8'h80, LB at 8 -> 64'hFFFF_FFFF_FFFF_FF80; LBU at 8 -> 64'h80.
REQ-034 SHALL cover: doubleword at 16 = 64'h1122_3344_5566_777D, SB at 16 with wdata 64'hAB -> MemWrite in C+2 with Write_Data=64'h1122_3344_5566_77AB; resp_valid at C+3.
REQ-035 SHALL cover: LW at addr 2 -> resp_error=1 at C+1, MemRead and MemWrite never asserted, resp_rdata=0.
REQ-036 SHALL cover: SH at 24 with reset asserted in RD -> MemWrite never asserted, memory unchanged, req_ready=1 on the cycle after reset.
REQ-037 SHALL cover: req_valid held high for three consecutive loads -> accepts only in IDLE, resp_valid every 3 cycles, none dropped or duplicated.
